// File: rtl/color_mix_pkg.sv
// Shared types and constants for the colour mixer pipeline and its fade controller.
package color_mix_pkg;

  typedef enum logic [2:0] {
    MODE_COLOR = 3'd0,
    MODE_GREEN = 3'd1,
    MODE_AMBER = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_WHITE = 3'd4
  } mode_e;

  localparam logic [15:0] LUMA_R_C = 16'd77;
  localparam logic [15:0] LUMA_G_C = 16'd150;
  localparam logic [15:0] LUMA_B_C = 16'd29;

  localparam int LEVEL_W = 5;
  localparam logic [LEVEL_W-1:0] FADE_MAX  = 5'd16;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 5'd0;

  typedef enum logic [1:0] {
    FADE_IDLE      = 2'd0,
    FADE_STEP_UP   = 2'd1,
    FADE_STEP_DOWN = 2'd2
  } fade_state_e;

  // (v * lvl) >> 4; lvl = 16 is an exact passthrough.
  function automatic logic [7:0] fade_scale(input logic [7:0] v, input logic [LEVEL_W-1:0] lvl);
    logic [12:0] prod;
    prod = {5'd0, v} * {8'd0, lvl};
    return 8'(prod >> 4'd4);
  endfunction

endpackage

// File: rtl/color_fade_ctrl.sv
// Frame-stepped fade level controller: VSync edge detect, frame counter and
// IDLE / STEP_UP / STEP_DOWN FSM moving the level one step per FADE_FRAMES frames.
module color_fade_ctrl
  import color_mix_pkg::*;
#(
  parameter int FADE_FRAMES = 1
) (
  input  logic               clk_vid,
  input  logic               reset,
  input  logic               ce_pix,
  input  logic               vsync,
  input  logic               fade_out,
  output logic [LEVEL_W-1:0] level,
  output logic               fade_busy
);

  localparam logic [7:0] FRAMES_M1 = 8'(FADE_FRAMES - 1);

  fade_state_e        state_r;
  fade_state_e        state_nx_s;
  logic               vs_prev_r;
  logic [7:0]         frame_cnt_r;
  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] target_s;
  logic               vs_rise_s;
  logic               step_up_s;
  logic               step_dn_s;
  logic               reverse_s;
  logic               frame_done_s;

  // Target level, edge detect and step qualifiers
  always_comb begin
    if (fade_out) begin
      target_s = LEVEL_MIN;
    end else begin
      target_s = FADE_MAX;
    end
    vs_rise_s    = vsync & ~vs_prev_r;
    frame_done_s = (frame_cnt_r >= FRAMES_M1);
    step_up_s    = vs_rise_s & (state_r == FADE_STEP_UP)   & (level_r < target_s);
    step_dn_s    = vs_rise_s & (state_r == FADE_STEP_DOWN) & (level_r > target_s);
    reverse_s    = ((state_r == FADE_STEP_UP)   && (state_nx_s == FADE_STEP_DOWN)) ||
                   ((state_r == FADE_STEP_DOWN) && (state_nx_s == FADE_STEP_UP));
  end

  // FSM state register
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      state_r <= FADE_IDLE;
    end else if (ce_pix) begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      FADE_IDLE: begin
        if (target_s > level_r) begin
          state_nx_s = FADE_STEP_UP;
        end else if (target_s < level_r) begin
          state_nx_s = FADE_STEP_DOWN;
        end else begin
          state_nx_s = FADE_IDLE;
        end
      end
      FADE_STEP_UP: begin
        if (level_r == target_s) begin
          state_nx_s = FADE_IDLE;
        end else if (target_s < level_r) begin
          state_nx_s = FADE_STEP_DOWN;
        end else begin
          state_nx_s = FADE_STEP_UP;
        end
      end
      FADE_STEP_DOWN: begin
        if (level_r == target_s) begin
          state_nx_s = FADE_IDLE;
        end else if (target_s > level_r) begin
          state_nx_s = FADE_STEP_UP;
        end else begin
          state_nx_s = FADE_STEP_DOWN;
        end
      end
      default: begin
        state_nx_s = FADE_IDLE;
      end
    endcase
  end

  // Edge history, frame counter and level; the counter restarts on direction reversal
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      vs_prev_r   <= 1'b0;
      frame_cnt_r <= 8'd0;
      level_r     <= FADE_MAX;
    end else if (ce_pix) begin
      vs_prev_r <= vsync;
      if (reverse_s || (state_r == FADE_IDLE)) begin
        frame_cnt_r <= 8'd0;
      end else if (step_up_s || step_dn_s) begin
        if (frame_done_s) begin
          frame_cnt_r <= 8'd0;
          if (step_up_s) begin
            level_r <= level_r + 5'd1;
          end else begin
            level_r <= level_r - 5'd1;
          end
        end else begin
          frame_cnt_r <= frame_cnt_r + 8'd1;
        end
      end
    end
  end

  // FSM outputs
  always_comb begin
    level     = level_r;
    fade_busy = (state_r != FADE_IDLE);
  end

endmodule

// File: rtl/color_mix_pipe.sv
// Three-stage video colour mixer: IW-bit expand, weighted-luma mono tint, fade scale.
// Define COLOR_MIX_FADE_EN to build the fade controller; otherwise stage 3 is a plain register.
module color_mix_pipe
  import color_mix_pkg::*;
#(
  parameter int IW          = 2,
  parameter int FADE_FRAMES = 1
) (
  input  logic          clk_vid,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [2:0]    mono,
  input  logic          fade_out,
  input  logic [IW-1:0] R_in,
  input  logic [IW-1:0] G_in,
  input  logic [IW-1:0] B_in,
  input  logic          HSync_in,
  input  logic          VSync_in,
  input  logic          HBlank_in,
  input  logic          VBlank_in,
  output logic [7:0]    R_out,
  output logic [7:0]    G_out,
  output logic [7:0]    B_out,
  output logic          HSync_out,
  output logic          VSync_out,
  output logic          HBlank_out,
  output logic          VBlank_out,
  output logic          fade_busy
);

  localparam int REP_W = 8 * IW;

  // Replicate MSB-first and keep the top 8 bits.
  function automatic logic [7:0] expand(input logic [IW-1:0] v);
    logic [REP_W-1:0] rep;
    rep = {8{v}};
    return 8'(rep >> (REP_W - 8));
  endfunction

  logic [7:0]  r1_r, g1_r, b1_r;
  logic [7:0]  r2_r, g2_r, b2_r;
  logic [7:0]  r3_r, g3_r, b3_r;
  logic [7:0]  r2_s, g2_s, b2_s;
  logic [7:0]  r3_s, g3_s, b3_s;
  logic [3:0]  sync1_r, sync2_r, sync3_r;
  logic [15:0] luma_sum_s;
  logic [7:0]  y_s;

  // Stage 1: component expansion and timing capture
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r1_r    <= 8'd0;
      g1_r    <= 8'd0;
      b1_r    <= 8'd0;
      sync1_r <= 4'd0;
    end else if (ce_pix) begin
      r1_r    <= expand(R_in);
      g1_r    <= expand(G_in);
      b1_r    <= expand(B_in);
      sync1_r <= {HSync_in, VSync_in, HBlank_in, VBlank_in};
    end
  end

  // Stage 2 combinational: luma and monochrome tint selection
  always_comb begin
    luma_sum_s = LUMA_R_C * {8'd0, r1_r} + LUMA_G_C * {8'd0, g1_r} + LUMA_B_C * {8'd0, b1_r};
    y_s        = 8'(luma_sum_s >> 4'd8);
    r2_s       = y_s;
    g2_s       = y_s;
    b2_s       = y_s;
    case (mono)
      MODE_COLOR: begin
        r2_s = r1_r;
        g2_s = g1_r;
        b2_s = b1_r;
      end
      MODE_GREEN: begin
        r2_s = 8'd0;
        g2_s = y_s;
        b2_s = 8'd0;
      end
      MODE_AMBER: begin
        r2_s = y_s;
        g2_s = y_s - {2'b00, y_s[7:2]};
        b2_s = 8'd0;
      end
      MODE_BLUE: begin
        r2_s = 8'd0;
        g2_s = 8'd0;
        b2_s = y_s;
      end
      default: begin
        r2_s = y_s;
        g2_s = y_s;
        b2_s = y_s;
      end
    endcase
  end

  // Stage 2 registers
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r2_r    <= 8'd0;
      g2_r    <= 8'd0;
      b2_r    <= 8'd0;
      sync2_r <= 4'd0;
    end else if (ce_pix) begin
      r2_r    <= r2_s;
      g2_r    <= g2_s;
      b2_r    <= b2_s;
      sync2_r <= sync1_r;
    end
  end

`ifdef COLOR_MIX_FADE_EN
  logic [LEVEL_W-1:0] level_s;

  color_fade_ctrl #(
    .FADE_FRAMES (FADE_FRAMES)
  ) u_fade_ctrl (
    .clk_vid   (clk_vid),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .vsync     (VSync_in),
    .fade_out  (fade_out),
    .level     (level_s),
    .fade_busy (fade_busy)
  );

  assign r3_s = fade_scale(r2_r, level_s);
  assign g3_s = fade_scale(g2_r, level_s);
  assign b3_s = fade_scale(b2_r, level_s);
`else
  logic fade_unused_s;

  assign fade_unused_s = fade_out;
  assign fade_busy     = 1'b0;
  assign r3_s          = r2_r;
  assign g3_s          = g2_r;
  assign b3_s          = b2_r;
`endif

  // Stage 3 registers drive the outputs directly
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r3_r    <= 8'd0;
      g3_r    <= 8'd0;
      b3_r    <= 8'd0;
      sync3_r <= 4'd0;
    end else if (ce_pix) begin
      r3_r    <= r3_s;
      g3_r    <= g3_s;
      b3_r    <= b3_s;
      sync3_r <= sync2_r;
    end
  end

  assign R_out      = r3_r;
  assign G_out      = g3_r;
  assign B_out      = b3_r;
  assign HSync_out  = sync3_r[3];
  assign VSync_out  = sync3_r[2];
  assign HBlank_out = sync3_r[1];
  assign VBlank_out = sync3_r[0];

endmodule
